issue_unit_param: RTL



---
 rtl/issue_unit_param.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/issue_unit_param.sv
// Tomasulo issue stage: ROB allocation, RAT rename and per-class RS capacity checks.
// Produces a registered dispatch packet one cycle after an instruction is accepted.
module issue_unit_param #(
  parameter int ROB_DEPTH = 8,
  parameter int NUM_REGS  = 16,
  parameter int REG_W     = 4,
  parameter int FUNC_W    = 4,
  parameter int ADD_RS    = 3,
  parameter int MUL_RS    = 3
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [REG_W-1:0]               in_rs1,
  input  logic [REG_W-1:0]               in_rs2,
  input  logic [REG_W-1:0]               in_rd,
  input  logic [FUNC_W-1:0]              in_func,
  input  logic                           add_free,
  input  logic                           mul_free,
  input  logic                           commit_valid,
  input  logic [REG_W-1:0]               commit_rd,
  input  logic                           flush,
  output logic                           out_valid,
  output logic                           out_class,
  output logic [FUNC_W-1:0]              out_func,
  output logic [REG_W-1:0]               out_rd,
  output logic [$clog2(ROB_DEPTH)-1:0]   out_rob_idx,
  output logic                           out_rs1_busy,
  output logic                           out_rs2_busy,
  output logic [$clog2(ROB_DEPTH)-1:0]   out_rs1_tag,
  output logic [$clog2(ROB_DEPTH)-1:0]   out_rs2_tag,
  output logic                           out_illegal,
  output logic [$clog2(ROB_DEPTH):0]     rob_count
);

  localparam int AW = $clog2(ROB_DEPTH);
  localparam int CW = $clog2(((ADD_RS > MUL_RS) ? ADD_RS : MUL_RS) + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(ROB_DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] ADD_MAX = CW'(ADD_RS);
  localparam logic [CW-1:0] MUL_MAX = CW'(MUL_RS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [AW:0]   head_p, tail_p;
  logic [CW-1:0] add_cnt, mul_cnt;
  logic          rat_busy [NUM_REGS];
  logic [AW-1:0] rat_tag  [NUM_REGS];
  logic [FUNC_W+REG_W-1:0] rob_mem [ROB_DEPTH];

  logic          full, empty, legal, is_mul, class_ok;
  logic          fire, issue, commit;
  logic [AW-1:0] head_idx, tail_idx;
  logic          rs1_busy, rs2_busy;
  logic          add_inc, add_dec, mul_inc, mul_dec;

  always_comb begin
    rob_count = tail_p - head_p;
    full      = (rob_count == DEPTH_C);
    empty     = (rob_count == '0);
    head_idx  = head_p[AW-1:0];
    tail_idx  = tail_p[AW-1:0];
    legal     = (in_func[FUNC_W-1:2] == '0);
    is_mul    = in_func[1];
    if (!legal)      class_ok = 1'b1;
    else if (is_mul) class_ok = (mul_cnt < MUL_MAX);
    else             class_ok = (add_cnt < ADD_MAX);
    in_ready  = !rst && !flush && !full && class_ok;
    fire      = in_valid && in_ready;
    issue     = fire && legal;
    commit    = commit_valid && !empty;
    // A retiring producer that owns the mapping makes the source ready this cycle.
    rs1_busy  = rat_busy[in_rs1] &&
                !(commit && (commit_rd == in_rs1) && (rat_tag[in_rs1] == head_idx));
    rs2_busy  = rat_busy[in_rs2] &&
                !(commit && (commit_rd == in_rs2) && (rat_tag[in_rs2] == head_idx));
    add_inc   = issue && !is_mul;
    mul_inc   = issue && is_mul;
    add_dec   = add_free && (add_cnt != '0);
    mul_dec   = mul_free && (mul_cnt != '0);
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      head_p  <= '0;
      tail_p  <= '0;
      add_cnt <= '0;
      mul_cnt <= '0;
    end else begin
      if (issue)  tail_p <= tail_p + PTR_ONE;
      if (commit) head_p <= head_p + PTR_ONE;
      if (add_inc && !add_dec)      add_cnt <= add_cnt + CNT_ONE;
      else if (!add_inc && add_dec) add_cnt <= add_cnt - CNT_ONE;
      if (mul_inc && !mul_dec)      mul_cnt <= mul_cnt + CNT_ONE;
      else if (!mul_inc && mul_dec) mul_cnt <= mul_cnt - CNT_ONE;
    end
  end

  // Issue write is placed after the commit clear so it wins on the same rd.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_REGS; i++) rat_busy[i] <= 1'b0;
    end else begin
      if (commit && rat_busy[commit_rd] && (rat_tag[commit_rd] == head_idx))
        rat_busy[commit_rd] <= 1'b0;
      if (issue) begin
        rat_busy[in_rd] <= 1'b1;
        rat_tag[in_rd]  <= tail_idx;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst && !flush && issue) rob_mem[tail_idx] <= {in_func, in_rd};
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      out_valid    <= 1'b0;
      out_illegal  <= 1'b0;
      out_class    <= 1'b0;
      out_func     <= '0;
      out_rd       <= '0;
      out_rob_idx  <= '0;
      out_rs1_busy <= 1'b0;
      out_rs2_busy <= 1'b0;
      out_rs1_tag  <= '0;
      out_rs2_tag  <= '0;
    end else begin
      out_valid   <= issue;
      out_illegal <= fire && !legal;
      if (issue) begin
        out_class    <= is_mul;
        out_func     <= in_func;
        out_rd       <= in_rd;
        out_rob_idx  <= tail_idx;
        out_rs1_busy <= rs1_busy;
        out_rs2_busy <= rs2_busy;
        out_rs1_tag  <= rat_tag[in_rs1];
        out_rs2_tag  <= rat_tag[in_rs2];
      end
    end
  end

endmodule
